// File: rtl/disp_pkg.sv
// Shared display code constants and the update-operation encoding for the display scanner.
package disp_pkg;

  typedef logic [3:0] disp_code_t;

  localparam disp_code_t CODE_BLANK = 4'hF;
  localparam disp_code_t CODE_BAR   = 4'hC;
  localparam disp_code_t CODE_A     = 4'hA;
  localparam disp_code_t CODE_P     = 4'hB;
  localparam disp_code_t CODE_N     = 4'hD;
  localparam disp_code_t CODE_E     = 4'hE;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_CLR,
    OP_SHIFT,
    OP_WRITE
  } disp_op_t;

  // Only one register update per cycle; lower-priority requests are dropped.
  function automatic disp_op_t pick_op(logic clr, logic shift_en, logic wr_en);
    if (clr)           return OP_CLR;
    else if (shift_en) return OP_SHIFT;
    else if (wr_en)    return OP_WRITE;
    else               return OP_NONE;
  endfunction

endpackage

// File: rtl/disp_scan_if.sv
// Front-panel display bus: digit update requests in, multiplexed code/enable out.
interface disp_scan_if
  import disp_pkg::*;
#(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              clr;
  logic              shift_en;
  disp_code_t        shift_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  disp_code_t        wr_data;
  logic [DIGITS-1:0] blink_mask;
  disp_code_t        data;
  logic [DIGITS-1:0] dig_sel;
  logic              scan_tick;

  modport master (
    output clr, shift_en, shift_data, wr_en, wr_addr, wr_data, blink_mask,
    input  data, dig_sel, scan_tick
  );

  modport slave (
    input  clr, shift_en, shift_data, wr_en, wr_addr, wr_data, blink_mask,
    output data, dig_sel, scan_tick
  );

endinterface

// File: rtl/disp_scan_tick_gen.sv
// Modulo-N counter emitting a single-cycle pulse while it sits at its terminal count N-1.
module tick_gen #(
  parameter int unsigned N = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(N - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/disp_scan.sv
// Multiplexed display scanner: per-digit code storage, scan divider, registered code/enable outputs.
// Optional blink of masked digits when DISP_BLINK_EN is defined.
module disp_scan
  import disp_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 250000
) (
  input  logic        clk,
  input  logic        rst,
  disp_scan_if.slave  bus
);

  localparam int unsigned AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  disp_code_t [DIGITS-1:0] dig_q, dig_d;
  logic [AW-1:0]           idx_q, idx_d;
  disp_code_t              data_q, data_d;
  logic [DIGITS-1:0]       dig_sel_q, dig_sel_d;
  logic                    scan_tick_q;
  logic                    scan_wrap;
  logic                    blank_d;
  disp_op_t                op;

  tick_gen #(.N(SCAN_DIV)) u_scan_div (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (scan_wrap)
  );

  always_comb begin
    op    = pick_op(bus.clr, bus.shift_en, bus.wr_en);
    dig_d = dig_q;
    unique case (op)
      OP_CLR:   dig_d = {DIGITS{CODE_BLANK}};
      OP_SHIFT: dig_d = {dig_q[DIGITS-2:0], bus.shift_data};
      OP_WRITE: begin
        // Addresses at or beyond DIGITS match no slot and are silently dropped.
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (bus.wr_addr == AW'(i)) dig_d[i] = bus.wr_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    if (scan_wrap) idx_d = (idx_q == AW'(DIGITS - 1)) ? '0 : idx_q + AW'(1);
  end

`ifdef DISP_BLINK_EN
  logic blink_wrap;
  logic phase_q, phase_d;

  tick_gen #(.N(BLINK_DIV)) u_blink_div (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (blink_wrap)
  );

  always_comb begin
    phase_d = phase_q ^ blink_wrap;
    blank_d = phase_d & bus.blink_mask[idx_d];
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= 1'b0;
    else     phase_q <= phase_d;
  end
`else
  always_comb blank_d = 1'b0;
`endif

  // Outputs look ahead at next-state values so an update shows up one cycle later.
  always_comb begin
    data_d    = blank_d ? CODE_BLANK : dig_d[idx_d];
    dig_sel_d = ~(DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q       <= {DIGITS{CODE_BLANK}};
      idx_q       <= '0;
      data_q      <= CODE_BLANK;
      dig_sel_q   <= ~DIGITS'(1);
      scan_tick_q <= 1'b0;
    end else begin
      dig_q       <= dig_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      dig_sel_q   <= dig_sel_d;
      scan_tick_q <= scan_wrap;
    end
  end

  assign bus.data      = data_q;
  assign bus.dig_sel   = dig_sel_q;
  assign bus.scan_tick = scan_tick_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan: a 4-digit and a 3-digit instance sharing clock and reset.
module tb_disp_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  disp_scan_if #(.DIGITS(4)) if4 ();
  disp_scan_if #(.DIGITS(3)) if3 ();

  disp_scan #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(8)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  disp_scan #(.DIGITS(3), .SCAN_DIV(4), .BLINK_DIV(8)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned k     = 0;   // cycles since the last reset edge
  logic [3:0]  exp4 [4];
  logic [3:0]  exp3 [3];
  logic [3:0]  mask4 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    int unsigned idx4;
    int unsigned idx3;
    logic [3:0]  sel4;
    logic [2:0]  sel3;
    logic        blank4;
    idx4   = (k / 4) % 4;
    idx3   = (k / 4) % 3;
    sel4   = ~(4'b0001 << idx4);
    sel3   = ~(3'b001 << idx3);
    blank4 = 1'b0;
`ifdef DISP_BLINK_EN
    blank4 = (((k / 8) % 2) == 1) && mask4[idx4];
`endif
    chk("data4", {28'd0, if4.data}, {28'd0, (blank4 ? 4'hF : exp4[idx4])});
    chk("sel4",  {28'd0, if4.dig_sel}, {28'd0, sel4});
    chk("tick4", {31'd0, if4.scan_tick}, {31'd0, ((k % 4) == 0) && (k > 0)});
    chk("data3", {28'd0, if3.data}, {28'd0, exp3[idx3]});
    chk("sel3",  {29'd0, if3.dig_sel}, {29'd0, sel3});
    chk("tick3", {31'd0, if3.scan_tick}, {31'd0, ((k % 4) == 0) && (k > 0)});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
    check_all();
  endtask

  task automatic blank_all();
    for (int i = 0; i < 4; i++) exp4[i] = 4'hF;
    for (int i = 0; i < 3; i++) exp3[i] = 4'hF;
  endtask

  task automatic shift4(input logic [3:0] v);
    if4.shift_en   = 1'b1;
    if4.shift_data = v;
    exp4[3] = exp4[2];
    exp4[2] = exp4[1];
    exp4[1] = exp4[0];
    exp4[0] = v;
    step();
    if4.shift_en = 1'b0;
  endtask

  initial begin
    if4.clr = 1'b0; if4.shift_en = 1'b0; if4.shift_data = '0;
    if4.wr_en = 1'b0; if4.wr_addr = '0; if4.wr_data = '0; if4.blink_mask = '0;
    if3.clr = 1'b0; if3.shift_en = 1'b0; if3.shift_data = '0;
    if3.wr_en = 1'b0; if3.wr_addr = '0; if3.wr_data = '0; if3.blink_mask = '0;
    blank_all();

    // Reset state and idle scanning.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    k   = 0;
    check_all();
    chk("rst_sel4", {28'd0, if4.dig_sel}, 32'h0000_000E);
    chk("rst_data4", {28'd0, if4.data}, 32'h0000_000F);
    repeat (20) step();

    // Random-access write to digit 2.
    if4.wr_en = 1'b1; if4.wr_addr = 2'd2; if4.wr_data = 4'h5;
    exp4[2] = 4'h5;
    step();
    if4.wr_en = 1'b0;
    repeat (16) step();

    // Write to the digit on display (k=37 -> 38, digit 1): visible next cycle.
    if4.wr_en = 1'b1; if4.wr_addr = 2'd1; if4.wr_data = 4'h9;
    exp4[1] = 4'h9;
    step();
    if4.wr_en = 1'b0;
    chk("wr_live_sel", {28'd0, if4.dig_sel}, 32'h0000_000D);
    chk("wr_live_data", {28'd0, if4.data}, 32'h0000_0009);
    repeat (3) step();

    // Shift in 1,2,3,4,7; the 1 falls off the left.
    shift4(4'h1); shift4(4'h2); shift4(4'h3); shift4(4'h4); shift4(4'h7);
    mask4 = 4'b0001; if4.blink_mask = mask4;
    repeat (16) step();
    mask4 = 4'b0000; if4.blink_mask = mask4;

    // clr beats shift and write in the same cycle; then a lone shift.
    if4.clr = 1'b1;
    if4.shift_en = 1'b1; if4.shift_data = 4'h6;
    if4.wr_en = 1'b1; if4.wr_addr = 2'd3; if4.wr_data = 4'h3;
    for (int i = 0; i < 4; i++) exp4[i] = 4'hF;
    step();
    if4.clr = 1'b0; if4.shift_en = 1'b0; if4.wr_en = 1'b0;
    shift4(4'h6);
    repeat (16) step();

    // 3-digit build: in-range write, then out-of-range address 3 ignored.
    if3.wr_en = 1'b1; if3.wr_addr = 2'd1; if3.wr_data = 4'hA;
    exp3[1] = 4'hA;
    step();
    if3.wr_addr = 2'd3; if3.wr_data = 4'h5;
    step();
    if3.wr_addr = 2'd0; if3.wr_data = 4'h4;
    exp3[0] = 4'h4;
    step();
    if3.wr_en = 1'b0;
    repeat (14) step();

    // Reset mid-scan and mid-write: full reset state next cycle.
    while ((k % 4) != 2) step();
    rst = 1'b1;
    if3.wr_en = 1'b1; if3.wr_addr = 2'd2; if3.wr_data = 4'h7;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    if3.wr_en = 1'b0;
    k = 0;
    blank_all();
    check_all();
    chk("midrst_sel3", {29'd0, if3.dig_sel}, 32'h0000_0006);
    chk("midrst_data3", {28'd0, if3.data}, 32'h0000_000F);
    repeat (8) step();

    // Masked digit 0 holding 8: blinks with the option, steady without it.
    if4.wr_en = 1'b1; if4.wr_addr = 2'd0; if4.wr_data = 4'h8;
    exp4[0] = 4'h8;
    step();
    if4.wr_en = 1'b0;
    mask4 = 4'b0001; if4.blink_mask = mask4;
    repeat (32) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
